// File: rtl/i2s_adc_capture_if.sv
// Write-side bus of the I2S ADC capture block. It carries the FIFO write
// port (sys_data_in/sys_we) and the recording status seen by the system.
//   sys_data_in : captured PCM word, held until the next write
//   sys_we      : one-cycle write strobe
//   sample_cnt  : words written since the last recording start
//   rec_busy    : recording in progress (arming, capturing or draining)
//   rec_full    : word limit reached
//   frame_err   : sticky short-word flag
// master = capture block, slave = FIFO / system side.
interface i2s_adc_capture_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] sys_data_in;
   logic              sys_we;
   logic [21:0]       sample_cnt;
   logic              rec_busy;
   logic              rec_full;
   logic              frame_err;

   modport master (
      output sys_data_in, sys_we, sample_cnt, rec_busy, rec_full, frame_err
   );

   modport slave (
      input sys_data_in, sys_we, sample_cnt, rec_busy, rec_full, frame_err
   );
endinterface

// File: rtl/i2s_adc_capture.sv
// WM8731 ADC capture: oversamples the codec serial pins on clk50M,
// deserialises PCM words and writes them to the SDRAM write FIFO while
// recording, aligned to whole stereo frames, up to MAX_WORDS words.
// Ports:
//   clk50M, reset          : system clock, async active-high reset
//   BCLK, ADCLRC, ADCDAT   : codec pins (asynchronous)
//   record_en              : record level
//   bus (master)           : FIFO write port and recording status
//
// state   | meaning
// IDLE    | not recording, waiting for a record_en rise
// ARM     | waiting for the start of a left channel
// CAPTURE | writing completed words
// DRAIN   | record_en dropped; finishing the current stereo frame
// FULL    | word limit reached, waiting for record_en to drop
module i2s_adc_capture #(
   parameter int          DATA_W    = 16,
   parameter int          I2S_DELAY = 1,
   parameter bit          STEREO    = 1'b1,
   parameter logic [21:0] MAX_WORDS = 22'h200000
) (
   input  logic              clk50M,
   input  logic              reset,
   input  logic              BCLK,
   input  logic              ADCLRC,
   input  logic              ADCDAT,
   input  logic              record_en,
   i2s_adc_capture_if.master bus
);
   localparam int         LAST     = I2S_DELAY + DATA_W - 1;
   localparam logic [5:0] LAST_IDX = 6'(LAST);

   typedef enum logic [2:0] {IDLE, ARM, CAPTURE, DRAIN, FULL} state_t;

   // [1:0] synchroniser, [2] history
   logic [2:0]        bclk_sr, lrc_sr, dat_sr;
   logic              rise, lrc_s, dat_s, lrc_chg;
   logic              lrc_prev, lrc_seen, got_word;
   logic [5:0]        bit_idx, idx_nxt;
   logic [DATA_W-1:0] shreg, shift_nxt;
   logic              word_rdy, word_ch, short_evt, left_start;
   logic [DATA_W-1:0] word_val;

   // LRC/DAT are taken from the history stage so they line up with the
   // BCLK edge detector, which compares stage 1 against stage 2.
   assign rise      = bclk_sr[1] & ~bclk_sr[2];
   assign lrc_s     = lrc_sr[2];
   assign dat_s     = dat_sr[2];
   assign shift_nxt = {shreg[DATA_W-2:0], dat_s};

   always_comb begin
      lrc_chg = rise & (lrc_s != lrc_prev);
      idx_nxt = bit_idx;
      if (lrc_chg)
         idx_nxt = 6'd0;
      else if (rise && bit_idx != 6'd63)
         idx_nxt = bit_idx + 6'd1;
   end

   always_ff @(posedge clk50M or posedge reset) begin
      if (reset) begin
         bclk_sr    <= '0;
         lrc_sr     <= '0;
         dat_sr     <= '0;
         lrc_prev   <= 1'b0;
         lrc_seen   <= 1'b0;
         got_word   <= 1'b0;
         bit_idx    <= '0;
         shreg      <= '0;
         word_rdy   <= 1'b0;
         word_ch    <= 1'b0;
         word_val   <= '0;
         short_evt  <= 1'b0;
         left_start <= 1'b0;
      end else begin
         bclk_sr    <= {bclk_sr[1:0], BCLK};
         lrc_sr     <= {lrc_sr[1:0], ADCLRC};
         dat_sr     <= {dat_sr[1:0], ADCDAT};
         word_rdy   <= 1'b0;
         short_evt  <= 1'b0;
         left_start <= 1'b0;
         if (rise) begin
            bit_idx <= idx_nxt;
            if (lrc_chg) begin
               lrc_prev   <= lrc_s;
               lrc_seen   <= 1'b1;
               got_word   <= 1'b0;
               // the first edge after reset has no channel before it to judge
               short_evt  <= lrc_seen & ~got_word;
               left_start <= ~lrc_s;
            end
            if (int'(idx_nxt) >= I2S_DELAY && int'(idx_nxt) <= LAST)
               shreg <= shift_nxt;
            if (idx_nxt == LAST_IDX && bit_idx != LAST_IDX) begin
               word_rdy <= 1'b1;
               word_val <= shift_nxt;
               word_ch  <= lrc_s;
               got_word <= 1'b1;
            end
         end
      end
   end

   state_t      state;
   logic        rec_q, last_left, rec_rise, can_write, hit_max;
   logic [21:0] cnt_inc;

   assign rec_rise  = record_en & ~rec_q;
   assign can_write = word_rdy & (~word_ch | STEREO);
   assign cnt_inc   = bus.sample_cnt + 22'd1;
   assign hit_max   = (cnt_inc == MAX_WORDS);

   always_ff @(posedge clk50M or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         // a level already high when reset releases is not a fresh start
         rec_q           <= 1'b1;
         last_left       <= 1'b0;
         bus.sys_data_in <= '0;
         bus.sys_we      <= 1'b0;
         bus.sample_cnt  <= '0;
         bus.rec_busy    <= 1'b0;
         bus.rec_full    <= 1'b0;
         bus.frame_err   <= 1'b0;
      end else begin
         rec_q      <= record_en;
         bus.sys_we <= 1'b0;
         if (rec_rise)
            bus.frame_err <= 1'b0;
         else if (short_evt)
            bus.frame_err <= 1'b1;

         case (state)
            IDLE: begin
               if (rec_rise) begin
                  bus.sample_cnt <= '0;
                  bus.rec_full   <= 1'b0;
                  bus.rec_busy   <= 1'b1;
                  last_left      <= 1'b0;
                  state          <= ARM;
               end
            end
            ARM: begin
               if (!record_en) begin
                  bus.rec_busy <= 1'b0;
                  state        <= IDLE;
               end else if (left_start) begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (can_write) begin
                  bus.sys_data_in <= word_val;
                  bus.sys_we      <= 1'b1;
                  bus.sample_cnt  <= cnt_inc;
                  last_left       <= ~word_ch;
               end
               if (can_write && hit_max) begin
                  bus.rec_full <= 1'b1;
                  bus.rec_busy <= 1'b0;
                  state        <= FULL;
               end else if (!record_en) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!(STEREO && last_left)) begin
                  bus.rec_busy <= 1'b0;
                  state        <= IDLE;
               end else if (word_rdy && word_ch) begin
                  bus.sys_data_in <= word_val;
                  bus.sys_we      <= 1'b1;
                  bus.sample_cnt  <= cnt_inc;
                  bus.rec_busy    <= 1'b0;
                  last_left       <= 1'b0;
                  if (hit_max) begin
                     bus.rec_full <= 1'b1;
                     state        <= FULL;
                  end else begin
                     state <= IDLE;
                  end
               end else if (word_rdy) begin
                  // a left word arrived first: the right word was lost
                  bus.rec_busy <= 1'b0;
                  state        <= IDLE;
               end
            end
            FULL: begin
               if (!record_en)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_i2s_adc_capture.sv
`timescale 1ns/1ps
module tb_i2s_adc_capture;
   localparam int EV_NONE = 0, EV_RISE = 1, EV_FALL = 2, EV_RST = 3;

   logic       clk50M = 1'b0;
   logic       reset  = 1'b1;
   logic       bclk   = 1'b0;
   logic       lrc    = 1'b1;
   logic       dat    = 1'b0;
   logic [2:0] rec_en = 3'b000;

   int n_checks = 0;
   int n_errors = 0;

   always #10 clk50M = ~clk50M;

   i2s_adc_capture_if #(.DATA_W(16)) bus_a ();
   i2s_adc_capture_if #(.DATA_W(16)) bus_b ();
   i2s_adc_capture_if #(.DATA_W(16)) bus_c ();

   // a: I2S stereo, b: left-justified mono, c: I2S stereo with a 5-word limit
   i2s_adc_capture #(.DATA_W(16), .I2S_DELAY(1), .STEREO(1'b1), .MAX_WORDS(22'h200000)) dut_a (
      .clk50M(clk50M), .reset(reset), .BCLK(bclk), .ADCLRC(lrc), .ADCDAT(dat),
      .record_en(rec_en[0]), .bus(bus_a.master));
   i2s_adc_capture #(.DATA_W(16), .I2S_DELAY(0), .STEREO(1'b0), .MAX_WORDS(22'h200000)) dut_b (
      .clk50M(clk50M), .reset(reset), .BCLK(bclk), .ADCLRC(lrc), .ADCDAT(dat),
      .record_en(rec_en[1]), .bus(bus_b.master));
   i2s_adc_capture #(.DATA_W(16), .I2S_DELAY(1), .STEREO(1'b1), .MAX_WORDS(22'd5)) dut_c (
      .clk50M(clk50M), .reset(reset), .BCLK(bclk), .ADCLRC(lrc), .ADCDAT(dat),
      .record_en(rec_en[2]), .bus(bus_c.master));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // write monitors
   logic [15:0] act_q [3][$];
   logic        prev_we [3] = '{default: 1'b0};

   task automatic mon(input int k, input logic we, input logic [15:0] d, input logic [21:0] cnt);
      if (we) begin
         chk("we_width", 32'(prev_we[k]), 32'd0);
         act_q[k].push_back(d);
         chk("cnt_at_we", 32'(cnt), act_q[k].size());
      end
      prev_we[k] = we;
   endtask

   always @(negedge clk50M) begin
      mon(0, bus_a.sys_we, bus_a.sys_data_in, bus_a.sample_cnt);
      mon(1, bus_b.sys_we, bus_b.sys_data_in, bus_b.sample_cnt);
      mon(2, bus_c.sys_we, bus_c.sys_data_in, bus_c.sample_cnt);
   end

   // reference: a channel is 32 bit slots, slot 0 follows the LRC edge;
   // the word sits MSB first at slots d .. d+15
   logic [15:0] exp_q [$];

   function automatic logic [31:0] place(input logic [15:0] w, input int d);
      logic [31:0] b;
      b = $urandom();
      b[31-d -: 16] = w;
      return b;
   endfunction

   task automatic cmp_writes(input int k, input string tag);
      chk({tag, "_count"}, act_q[k].size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < act_q[k].size(); i++)
         chk(tag, 32'(act_q[k][i]), 32'(exp_q[i]));
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk50M);
      #2;
   endtask

   task automatic do_event(input int act, input int k);
      case (act)
         EV_RISE: begin
            act_q[k].delete();
            rec_en[k] = 1'b1;
         end
         EV_FALL: rec_en[k] = 1'b0;
         EV_RST: begin
            #3 reset = 1'b1;
            #1;
            chk("rst_we",   32'(bus_a.sys_we), 32'd0);
            chk("rst_data", 32'(bus_a.sys_data_in), 32'd0);
            chk("rst_cnt",  32'(bus_a.sample_cnt), 32'd0);
            chk("rst_busy", 32'(bus_a.rec_busy), 32'd0);
            #4 reset = 1'b0;
         end
         default: ;
      endcase
   endtask

   // one channel: data changes on BCLK fall, codec samples on the rise
   task automatic send_chan(input logic l, input logic [31:0] bits, input int len,
                            input int ev_bit, input int ev_act, input int ev_k);
      for (int b = 0; b < len; b++) begin
         tick(1);
         bclk = 1'b0;
         lrc  = l;
         dat  = bits[31-b];
         if (b == ev_bit) do_event(ev_act, ev_k);
         tick(10);
         bclk = 1'b1;
         tick(9);
      end
   endtask

   task automatic send_frame(input logic [31:0] lb, input logic [31:0] rb);
      send_chan(1'b0, lb, 32, -1, EV_NONE, 0);
      send_chan(1'b1, rb, 32, -1, EV_NONE, 0);
   endtask

   initial begin
      logic [15:0] lw, rw;
      tick(5);
      chk("rst_a_we",   32'(bus_a.sys_we), 32'd0);
      chk("rst_a_cnt",  32'(bus_a.sample_cnt), 32'd0);
      chk("rst_a_busy", 32'(bus_a.rec_busy), 32'd0);
      chk("rst_a_full", 32'(bus_a.rec_full), 32'd0);
      chk("rst_a_err",  32'(bus_a.frame_err), 32'd0);
      chk("rst_c_data", 32'(bus_c.sys_data_in), 32'd0);
      reset = 1'b0;
      tick(5);
      send_chan(1'b1, $urandom(), 32, -1, EV_NONE, 0);
      send_chan(1'b0, $urandom(), 32, -1, EV_NONE, 0);

      // I2S stereo, start mid-right, stop during a left channel after its word
      exp_q.delete();
      send_chan(1'b1, $urandom(), 32, 5, EV_RISE, 0);
      chk("arm_busy", 32'(bus_a.rec_busy), 32'd1);
      for (int f = 0; f < 5; f++) begin
         lw = (f == 0) ? 16'hA5C3 : 16'($urandom());
         rw = (f == 0) ? 16'h0F0F : 16'($urandom());
         exp_q.push_back(lw);
         exp_q.push_back(rw);
         send_chan(1'b0, place(lw, 1), 32, (f == 4) ? 25 : -1, EV_FALL, 0);
         send_chan(1'b1, place(rw, 1), 32, -1, EV_NONE, 0);
         if (f == 0) begin
            chk("cnt_one_frame", 32'(bus_a.sample_cnt), 32'd2);
            chk("busy_capture", 32'(bus_a.rec_busy), 32'd1);
         end
      end
      send_frame($urandom(), $urandom());
      cmp_writes(0, "stereo_word");
      chk("drain_busy", 32'(bus_a.rec_busy), 32'd0);
      chk("drain_cnt", 32'(bus_a.sample_cnt), 32'd10);
      chk("drain_even", 32'(bus_a.sample_cnt[0]), 32'd0);

      // left-justified mono
      exp_q.delete();
      send_chan(1'b1, $urandom(), 32, 5, EV_RISE, 1);
      for (int f = 0; f < 5; f++) begin
         lw = (f == 0) ? 16'h8001 : 16'($urandom());
         exp_q.push_back(lw);
         send_chan(1'b0, place(lw, 0), 32, (f == 4) ? 25 : -1, EV_FALL, 1);
         send_chan(1'b1, $urandom(), 32, -1, EV_NONE, 0);
      end
      send_frame($urandom(), $urandom());
      cmp_writes(1, "mono_word");
      chk("mono_busy", 32'(bus_b.rec_busy), 32'd0);

      // 5-word limit: the right word of the third frame is suppressed
      exp_q.delete();
      send_chan(1'b1, $urandom(), 32, 5, EV_RISE, 2);
      for (int f = 0; f < 4; f++) begin
         lw = 16'($urandom());
         rw = 16'($urandom());
         if (exp_q.size() < 5) exp_q.push_back(lw);
         if (exp_q.size() < 5) exp_q.push_back(rw);
         send_frame(place(lw, 1), place(rw, 1));
      end
      cmp_writes(2, "limit_word");
      chk("limit_full", 32'(bus_c.rec_full), 32'd1);
      chk("limit_busy", 32'(bus_c.rec_busy), 32'd0);
      chk("limit_cnt", 32'(bus_c.sample_cnt), 32'd5);
      send_chan(1'b0, $urandom(), 32, 5, EV_FALL, 2);
      chk("full_sticky", 32'(bus_c.rec_full), 32'd1);
      send_chan(1'b1, $urandom(), 32, 5, EV_RISE, 2);
      chk("rearm_busy", 32'(bus_c.rec_busy), 32'd1);
      chk("rearm_full", 32'(bus_c.rec_full), 32'd0);
      chk("rearm_cnt", 32'(bus_c.sample_cnt), 32'd0);
      send_chan(1'b0, $urandom(), 32, 5, EV_FALL, 2);
      send_chan(1'b1, $urandom(), 32, -1, EV_NONE, 0);

      // short left channel (10 bits) inside a recording
      exp_q.delete();
      send_chan(1'b1, $urandom(), 32, 5, EV_RISE, 0);
      for (int f = 0; f < 4; f++) begin
         lw = 16'($urandom());
         rw = 16'($urandom());
         if (f != 1) exp_q.push_back(lw);
         exp_q.push_back(rw);
         send_chan(1'b0, place(lw, 1), (f == 1) ? 10 : 32, (f == 3) ? 25 : -1, EV_FALL, 0);
         send_chan(1'b1, place(rw, 1), 32, -1, EV_NONE, 0);
         if (f == 0) chk("err_before_short", 32'(bus_a.frame_err), 32'd0);
         if (f == 1) chk("err_after_short", 32'(bus_a.frame_err), 32'd1);
      end
      send_frame($urandom(), $urandom());
      cmp_writes(0, "short_word");
      chk("err_sticky", 32'(bus_a.frame_err), 32'd1);

      // new recording clears the flag; then reset lands mid-word
      send_chan(1'b1, $urandom(), 32, 5, EV_RISE, 0);
      chk("err_cleared", 32'(bus_a.frame_err), 32'd0);
      send_frame($urandom(), $urandom());
      chk("pre_rst_cnt", 32'(bus_a.sample_cnt), 32'd2);
      send_chan(1'b0, $urandom(), 32, 8, EV_RST, 0);
      send_chan(1'b1, $urandom(), 32, -1, EV_NONE, 0);
      send_frame($urandom(), $urandom());
      chk("post_rst_writes", act_q[0].size(), 32'd2);
      chk("post_rst_busy", 32'(bus_a.rec_busy), 32'd0);
      chk("post_rst_cnt", 32'(bus_a.sample_cnt), 32'd0);
      rec_en = 3'b000;
      tick(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
